// File: rtl/alu_ctrl_pkg.sv
// FSM state encoding and defaults for the ALU sharing arbiter.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   localparam int unsigned ALU_LATENCY_DEFAULT = 2;

   function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/opcodes_pkg.sv
// Instruction and register types shared by the ALU and the logic that feeds it.
package opcodes;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] register_t;

   typedef enum logic [3:0] {
      M_ADD = 4'd0,
      M_SUB = 4'd1,
      M_AND = 4'd2,
      M_OR  = 4'd3,
      M_XOR = 4'd4,
      M_SLL = 4'd5,
      M_SRL = 4'd6,
      M_SRA = 4'd7
   } alu_op_t;

   typedef struct packed {
      logic [27:0] imm;
      alu_op_t     op;
   } instruction_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker; ALU_ARB_FIXED_PRIO_EN swaps in lowest-index-wins priority.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx
);

   logic found;

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            idx      = IDX_W'(i);
         end
      end
   end
`else
   int unsigned j;

   // Scan upward from ptr with wrap-around; first valid request wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = (32'(ptr) + i) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU between NUM_REQ requesters, one operation in flight.
// ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
   import alu_ctrl_pkg::*;
   import opcodes::*;
#(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned ALU_LATENCY = ALU_LATENCY_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  instruction_t               req_instr [NUM_REQ],
   input  register_t                  req_op1   [NUM_REQ],
   input  register_t                  req_op2   [NUM_REQ],
   input  register_t                  req_pc    [NUM_REQ],
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output register_t                  rsp_result,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output instruction_t               alu_instr,
   output register_t                  alu_op1,
   output register_t                  alu_op2,
   output register_t                  alu_pc,
   output logic                       alu_enable,
   input  register_t                  alu_result,
   output logic                       busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

   arb_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               armed;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   arb_ptr;
   logic               handshake;

   instruction_t       alu_instr_d;
   register_t          alu_op1_d, alu_op2_d, alu_pc_d, rsp_result_d;
   logic [IDX_W-1:0]   rsp_id_d;
   logic [NUM_REQ-1:0] rsp_valid_d;
   logic               alu_enable_d, busy_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

   assign arb_ptr = ptr_q;
`endif

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (arb_ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   // armed keeps req_ready low while reset is asserted, without a combinational reset path.
   assign req_ready = (state_q == IDLE && armed) ? grant : '0;
   assign handshake = |(req_valid & req_ready);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_instr_d  = alu_instr;
      alu_op1_d    = alu_op1;
      alu_op2_d    = alu_op2;
      alu_pc_d     = alu_pc;
      rsp_result_d = rsp_result;
      rsp_id_d     = rsp_id;
      rsp_valid_d  = '0;
      alu_enable_d = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_d        = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d      = ISSUE;
               alu_instr_d  = req_instr[grant_idx];
               alu_op1_d    = req_op1[grant_idx];
               alu_op2_d    = req_op2[grant_idx];
               alu_pc_d     = req_pc[grant_idx];
               rsp_id_d     = grant_idx;
               alu_enable_d = 1'b1;
            end
         end
         ISSUE: begin
            if (ALU_LATENCY > 1) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(ALU_LATENCY - 1);
            end else begin
               state_d             = RESP;
               rsp_result_d        = alu_result;
               rsp_valid_d[rsp_id] = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d             = RESP;
               rsp_result_d        = alu_result;
               rsp_valid_d[rsp_id] = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready[rsp_id]) begin
               state_d = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
               ptr_d   = IDX_W'(wrap_inc(32'(rsp_id), NUM_REQ));
`endif
            end else begin
               rsp_valid_d[rsp_id] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         armed      <= 1'b0;
         alu_instr  <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_pc     <= '0;
         alu_enable <= 1'b0;
         rsp_result <= '0;
         rsp_id     <= '0;
         rsp_valid  <= '0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         armed      <= 1'b1;
         alu_instr  <= alu_instr_d;
         alu_op1    <= alu_op1_d;
         alu_op2    <= alu_op2_d;
         alu_pc     <= alu_pc_d;
         alu_enable <= alu_enable_d;
         rsp_result <= rsp_result_d;
         rsp_id     <= rsp_id_d;
         rsp_valid  <= rsp_valid_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: default build plus a single-cycle-latency instance.
module tb_alu_arbiter;
   import opcodes::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Main instance, ALU_LATENCY = 2
   logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   instruction_t req_instr [2];
   register_t    req_op1 [2], req_op2 [2], req_pc [2];
   register_t    rsp_result, alu_op1, alu_op2, alu_pc, alu_result, alu_pipe;
   logic [0:0]   rsp_id;
   instruction_t alu_instr;
   logic         alu_enable, busy;

   // Second instance, ALU_LATENCY = 1
   logic [1:0]   req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
   instruction_t req_instr_b [2];
   register_t    req_op1_b [2], req_op2_b [2], req_pc_b [2];
   register_t    rsp_result_b, alu_op1_b, alu_op2_b, alu_pc_b, alu_result_b;
   logic [0:0]   rsp_id_b;
   instruction_t alu_instr_b;
   logic         alu_enable_b, busy_b;

   function automatic register_t alu_f(input instruction_t i, input register_t a, input register_t b);
      case (i.op)
         M_ADD:   return a + b;
         M_SUB:   return a - b;
         M_AND:   return a & b;
         M_OR:    return a | b;
         M_XOR:   return a ^ b;
         M_SLL:   return a << b[4:0];
         M_SRL:   return a >> b[4:0];
         M_SRA:   return register_t'($signed(a) >>> b[4:0]);
         default: return '0;
      endcase
   endfunction

   // ALU models: result valid only in the window the arbiter should capture it.
   always @(posedge clk)
      alu_pipe <= alu_enable ? alu_f(alu_instr, alu_op1, alu_op2) : 32'hDEADBEEF;
   assign alu_result   = alu_pipe;
   assign alu_result_b = alu_enable_b ? alu_f(alu_instr_b, alu_op1_b, alu_op2_b) : 32'hDEADBEEF;

   alu_arbiter #(.NUM_REQ(2), .ALU_LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_instr(req_instr), .req_op1(req_op1), .req_op2(req_op2), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id),
      .alu_instr(alu_instr), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_pc(alu_pc),
      .alu_enable(alu_enable), .alu_result(alu_result), .busy(busy)
   );

   alu_arbiter #(.NUM_REQ(2), .ALU_LATENCY(1)) dut_lat1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_instr(req_instr_b), .req_op1(req_op1_b), .req_op2(req_op2_b), .req_pc(req_pc_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_result(rsp_result_b), .rsp_id(rsp_id_b),
      .alu_instr(alu_instr_b), .alu_op1(alu_op1_b), .alu_op2(alu_op2_b), .alu_pc(alu_pc_b),
      .alu_enable(alu_enable_b), .alu_result(alu_result_b), .busy(busy_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int id, input alu_op_t op, input register_t a, input register_t b);
      req_instr[id] = '{imm: 28'(id), op: op};
      req_op1[id]   = a;
      req_op2[id]   = b;
      req_pc[id]    = 32'h100 + 32'(id) * 4;
   endtask

   // Steps negedges until a response shows up; lat counts negedges since the handshake.
   task automatic wait_rsp(inout int lat, inout int en_cnt);
      while (rsp_valid == 2'b00 && lat < 12) begin
         @(negedge clk);
         lat++;
         en_cnt += int'(alu_enable);
      end
   endtask

   // Full single operation on one requester; called at a negedge with the arbiter idle.
   task automatic run_op(input int id, input alu_op_t op, input register_t a,
                         input register_t b, input register_t exp);
      int lat, en_cnt;
      set_req(id, op, a, b);
      req_valid[id] = 1'b1;
      #1 check("req_ready grant", 32'(req_ready), 32'(1) << id);
      @(posedge clk);
      @(negedge clk);
      req_valid[id] = 1'b0;
      check("busy in ISSUE", 32'(busy), 32'd1);
      check("alu_enable in ISSUE", 32'(alu_enable), 32'd1);
      check("alu_instr op", 32'(alu_instr.op), 32'(op));
      check("alu_pc", alu_pc, 32'h100 + 32'(id) * 4);
      lat    = 1;
      en_cnt = 1;
      wait_rsp(lat, en_cnt);
      check("rsp latency", 32'(lat), 32'd3);
      check("alu_enable cycles", 32'(en_cnt), 32'd1);
      check("rsp_valid owner", 32'(rsp_valid), 32'(1) << id);
      check("rsp_result", rsp_result, exp);
      check("rsp_id", 32'(rsp_id), 32'(id));
      check("alu_op2 held", alu_op2, b);
      rsp_ready[id] = 1'b1;
      @(negedge clk);
      rsp_ready[id] = 1'b0;
      check("busy after retire", 32'(busy), 32'd0);
      check("rsp_valid after retire", 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      int        id;
      alu_op_t   op;
      register_t a;
      register_t b;
      register_t exp;
   } vec_t;

   vec_t vecs [6];
   int   exp_g [4];

   initial begin
      int lat, en_cnt, bcnt;

      vecs[0] = '{0, M_ADD, 32'd5,         32'd7,         32'd12};
      vecs[1] = '{1, M_SUB, 32'd3,         32'd5,         32'hFFFFFFFE};
      vecs[2] = '{0, M_AND, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000};
      vecs[3] = '{1, M_OR,  32'h0F0F0000,  32'h0000F0F0,  32'h0F0FF0F0};
      vecs[4] = '{0, M_SRL, 32'h80000000,  32'd31,        32'd1};
      vecs[5] = '{1, M_SLL, 32'd3,         32'd4,         32'd48};
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 0, 1};
`endif

      rst = 1'b0;
      req_valid = '0; rsp_ready = '0; req_valid_b = '0; rsp_ready_b = '0;
      for (int i = 0; i < 2; i++) begin
         set_req(i, M_ADD, '0, '0);
         req_instr_b[i] = '0; req_op1_b[i] = '0; req_op2_b[i] = '0; req_pc_b[i] = '0;
      end
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset alu_enable", 32'(alu_enable), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_result", rsp_result, 32'd0);
      check("reset alu_op1", alu_op1, 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single operations from the vector table
      for (int v = 0; v < 6; v++)
         run_op(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);

      // Contention: both requesters held valid across four operations
      set_req(0, M_ADD, 32'd10, 32'd1);
      set_req(1, M_ADD, 32'd20, 32'd2);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1 check("contention grant", 32'(req_ready), 32'(1) << exp_g[k]);
         @(posedge clk);
         @(negedge clk);
         lat = 1; en_cnt = 1;
         wait_rsp(lat, en_cnt);
         check("contention rsp_id", 32'(rsp_id), 32'(exp_g[k]));
         check("contention result", rsp_result, (exp_g[k] == 0) ? 32'd11 : 32'd22);
         rsp_ready = rsp_valid;
         @(negedge clk);
         rsp_ready = '0;
      end
      req_valid = '0;
      @(negedge clk);

      // Response backpressure plus a wrong-owner rsp_ready pulse
      set_req(1, M_XOR, 32'hAAAA5555, 32'h5555AAAA);
      req_valid = 2'b10;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b01;
      lat = 1; en_cnt = 1;
      wait_rsp(lat, en_cnt);
      bcnt = 0;
      for (int c = 0; c < 10; c++) begin
         check("bp rsp_valid", 32'(rsp_valid), 32'b10);
         check("bp rsp_result", rsp_result, 32'hFFFFFFFF);
         check("bp req_ready", 32'(req_ready), 32'd0);
         check("bp busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("wrong owner busy", 32'(busy), 32'd1);
      check("wrong owner rsp_valid", 32'(rsp_valid), 32'b10);
      req_valid = 2'b00;
      rsp_ready = 2'b10;
      @(negedge clk);
      rsp_ready = 2'b00;
      check("bp retired", 32'(busy), 32'd0);

      // Latency-1 instance: capture on the edge ending ISSUE
      req_instr_b[0] = '{imm: 28'd0, op: M_SLL};
      req_op1_b[0]   = 32'd1;
      req_op2_b[0]   = 32'd31;
      req_valid_b    = 2'b01;
      #1 check("lat1 grant", 32'(req_ready_b), 32'b01);
      @(posedge clk);
      @(negedge clk);
      req_valid_b = 2'b00;
      check("lat1 enable", 32'(alu_enable_b), 32'd1);
      bcnt = 1;
      while (rsp_valid_b == 2'b00 && bcnt < 10) begin
         @(negedge clk);
         bcnt++;
      end
      check("lat1 rsp latency", 32'(bcnt), 32'd2);
      check("lat1 rsp_result", rsp_result_b, 32'h80000000);
      rsp_ready_b = 2'b01;
      @(negedge clk);
      rsp_ready_b = 2'b00;
      check("lat1 occupancy idle", 32'(busy_b), 32'd0);

      // Reset during WAIT with req1 pending
      set_req(0, M_ADD, 32'd1, 32'd1);
      req_valid = 2'b01;
      @(posedge clk);
      @(negedge clk);
      set_req(1, M_ADD, 32'd100, 32'd23);
      req_valid = 2'b10;
      @(negedge clk);
      check("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("abort alu_enable", 32'(alu_enable), 32'd0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort rsp_id", 32'(rsp_id), 32'd0);
      check("abort req_ready", 32'(req_ready), 32'd0);
      check("abort alu_op1", alu_op1, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("no stale rsp", 32'(rsp_valid), 32'd0);
      run_op(1, M_ADD, 32'd100, 32'd23, 32'd123);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
